ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: an M-extension instruction occupies the EX stage.
REQ-005 The block SHALL have port op, input, 3 bits: funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-006 The block SHALL have ports srca and srcb, input, XLEN bits each: the forwarded rs1 and rs2 values.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous kill of the EX stage.
REQ-008 The block SHALL have port stall, output, 1 bit: holds the IF/ID/EX stages.
REQ-009 The block SHALL have port done, output, 1 bit: result valid this cycle.
REQ-010 The block SHALL have port result, output, XLEN bits: the registered result.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-012 In IDLE, start=1 and flush=0 SHALL register the operand magnitudes and op, clear the counter, and move to MUL (op<4) or DIV (op>=4).
REQ-013 In IDLE, a divisor of 0 or a signed overflow (DIV/REM with srca=min and srcb=-1) SHALL skip the iteration and go directly to DONE with the special result.
REQ-014 MUL SHALL perform one shift-add step per cycle over a 2*XLEN-bit product, for exactly XLEN cycles, then go to FIX.
REQ-015 DIV SHALL perform one restoring-division step per cycle, for exactly XLEN cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction, select the low half (MUL), high half (MULH*), quotient or remainder, register result, and go to DONE.
REQ-017 Signedness SHALL be: MULH both operands signed; MULHSU srca signed, srcb unsigned; DIV/REM signed; the remainder takes the dividend's sign.
REQ-018 Divide by zero SHALL give quotient all-ones and remainder srca.
REQ-019 Signed overflow SHALL give quotient = min (1 followed by XLEN-1 zeros) and remainder 0.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-021 start SHALL be ignored in DONE, because it is the same instruction still in EX.
REQ-022 stall SHALL be combinational: (state==IDLE & start & ~flush) | state in {MUL, DIV, FIX}; stall SHALL be 0 in DONE.
REQ-023 Latency SHALL be: start accepted at edge k gives done high in the cycle after edge k+XLEN+1, i.e. XLEN+2 stall cycles for the iterative path and 1 stall cycle for the special-case path.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge with done=0 and result unchanged; flush has priority over start.
REQ-025 result SHALL hold its last value outside DONE.
REQ-026 The iteration counter SHALL be $clog2(XLEN)+1 bits wide and SHALL never wrap within one operation.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, counter=0, result=0, done=0 and stall=0, including in the middle of an operation.
REQ-028 Release of reset SHALL take effect at the first clk edge after deassertion; no operation SHALL be in flight afterwards.

Structure
REQ-029 The opcode encodings, the FSM state enum and an XLEN-derived min-value function SHALL live in the shared package riscv_pkg.
REQ-030 The design SHALL be a single module with one always_ff for the state, counter and datapath registers and one always_comb for next-state and stall.
REQ-031 No sub-module SHALL be instantiated; the adder/subtractor SHALL be inferred and shared between MUL and DIV.

Verification
REQ-032 The bench SHALL cover MUL srca=7, srcb=-3 -> result 0xFFFFFFEB, stall high for 34 cycles, then done.
REQ-033 The bench SHALL cover MULHU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> result 0xFFFFFFFE, and MULHSU srca=-1, srcb=0xFFFFFFFF -> result 0xFFFFFFFF.
REQ-034 The bench SHALL cover DIV srca=-7, srcb=2 -> result -3, and REM with the same operands -> result -1.
REQ-035 The bench SHALL cover DIVU srca=5, srcb=0 -> result 0xFFFFFFFF after 1 stall cycle, and DIV srca=0x80000000, srcb=-1 -> result 0x80000000.
REQ-036 The bench SHALL cover flush asserted 10 cycles into a DIV -> IDLE next cycle, no done pulse, and a following MUL 3*4 -> result 12.
REQ-037 The bench SHALL cover reset pulsed low mid-MUL -> stall, done and result 0 immediately, with no done pulse after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared M-extension opcodes, muldiv FSM states and helpers
package riscv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  function automatic logic [63:0] min_val(input int xlen);
    return 64'd1 << (xlen - 1);
  endfunction
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative shift-add multiplier / restoring divider for the EX stage
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] opr;
  logic [XLEN-1:0] hi, lo, b, minv, abs_a, abs_b, spec_res, q, r;
  logic [XLEN:0] x, y, sum, t;
  logic [2*XLEN-1:0] p;
  logic negq, negr, sa, sb, div0, ovf, special, sub, accept;
  assign minv = XLEN'(min_val(XLEN));
  assign sa = ~op[2] ? (op != OP_MULHU) : ~op[0];
  assign sb = ~op[2] ? ~op[1] : ~op[0];
  assign abs_a = (sa & srca[XLEN-1]) ? -srca : srca;
  assign abs_b = (sb & srcb[XLEN-1]) ? -srcb : srcb;
  assign div0 = op[2] & (srcb == '0);
  assign ovf = (op == OP_DIV || op == OP_REM) & (srca == minv) & (&srcb);
  assign special = div0 | ovf;
  assign spec_res = div0 ? (op[1] ? srca : '1) : (op[1] ? '0 : minv);
  assign accept = (state == IDLE) & start & ~flush;
  assign sub = state == DIV;
  assign x = sub ? {hi, lo[XLEN-1]} : {1'b0, hi};
  assign y = {1'b0, b};
  assign sum = x + (y ^ {(XLEN+1){sub}}) + (XLEN+1)'(sub);
  assign t = lo[0] ? sum : x;
  assign p = negq ? -{hi, lo} : {hi, lo};
  assign q = negq ? -lo : lo;
  assign r = negr ? -hi : hi;
  assign done = state == DONE;
  // next state and stage stall
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (special ? DONE : (op[2] ? DIV : MUL)) : IDLE;
      MUL,
      DIV:     state_n = (cnt == CW'(XLEN - 1)) ? FIX : state;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    state_n = flush ? IDLE : state_n;
    stall = accept | (state == MUL) | (state == DIV) | (state == FIX);
  end
  // state, counter and datapath registers; flush only redirects the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      opr    <= '0;
      hi     <= '0;
      lo     <= '0;
      b      <= '0;
      negq   <= 1'b0;
      negr   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        opr  <= op;
        hi   <= '0;
        lo   <= abs_a;
        b    <= abs_b;
        cnt  <= '0;
        negq <= (sa & srca[XLEN-1]) ^ (sb & srcb[XLEN-1]);
        negr <= sa & srca[XLEN-1];
        if (special) result <= spec_res;
      end else if (!flush && state == MUL) begin
        hi  <= t[XLEN:1];
        lo  <= {t[0], lo[XLEN-1:1]};
        cnt <= cnt + CW'(1);
      end else if (!flush && state == DIV) begin
        hi  <= sum[XLEN] ? x[XLEN-1:0] : sum[XLEN-1:0];
        lo  <= {lo[XLEN-2:0], ~sum[XLEN]};
        cnt <= cnt + CW'(1);
      end else if (!flush && state == FIX) begin
        result <= opr[2] ? (opr[1] ? r : q) : (opr == OP_MUL ? p[XLEN-1:0] : p[2*XLEN-1:XLEN]);
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of the iterative mul/div unit
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic flush = 1'b0;
  logic stall, done;
  logic [31:0] result;
  int checks = 0;
  int failures = 0;
  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                        output int stalls, output logic [31:0] res, output bit ok);
    @(negedge clk);
    op = o; srca = a; srcb = bb; start = 1'b1;
    stalls = 0; ok = 0; res = '0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        res = result; ok = 1;
        break;
      end
      if (stall) stalls++;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk); reset = 1'b1;
  endtask
  task automatic test_mul();
    int s; logic [31:0] res; bit ok;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h ok=%0d exp=ffffffeb", res, ok); end
    checks++; if (s !== 34) begin failures++; $display("FAIL mul_stalls got=%0d exp=34", s); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mul_stall_in_done got=%b exp=0", stall); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_one_cycle got=%b exp=0", done); end
    checks++; if (result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result_hold got=%h exp=ffffffeb", result); end
  endtask
  task automatic test_mulh();
    int s; logic [31:0] res; bit ok;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu got=%h ok=%0d exp=fffffffe", res, ok); end
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got=%h ok=%0d exp=ffffffff", res, ok); end
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulh got=%h ok=%0d exp=ffffffff", res, ok); end
  endtask
  task automatic test_div();
    int s; logic [31:0] res; bit ok;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFD) begin failures++; $display("FAIL div got=%h ok=%0d exp=fffffffd", res, ok); end
    checks++; if (s !== 34) begin failures++; $display("FAIL div_stalls got=%0d exp=34", s); end
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem got=%h ok=%0d exp=ffffffff", res, ok); end
    run_op(3'd5, 32'd100, 32'd7, s, res, ok);
    checks++; if (!ok || res !== 32'd14) begin failures++; $display("FAIL divu got=%h ok=%0d exp=0000000e", res, ok); end
    run_op(3'd7, 32'd100, 32'd7, s, res, ok);
    checks++; if (!ok || res !== 32'd2) begin failures++; $display("FAIL remu got=%h ok=%0d exp=00000002", res, ok); end
  endtask
  task automatic test_special();
    int s; logic [31:0] res; bit ok;
    run_op(3'd5, 32'd5, 32'd0, s, res, ok);
    checks++; if (!ok || res !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_by_zero got=%h ok=%0d exp=ffffffff", res, ok); end
    checks++; if (s !== 1) begin failures++; $display("FAIL div0_stalls got=%0d exp=1", s); end
    run_op(3'd6, 32'd5, 32'd0, s, res, ok);
    checks++; if (!ok || res !== 32'd5) begin failures++; $display("FAIL rem_by_zero got=%h ok=%0d exp=00000005", res, ok); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, s, res, ok);
    checks++; if (!ok || res !== 32'h0) begin failures++; $display("FAIL rem_overflow got=%h ok=%0d exp=0", res, ok); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, s, res, ok);
    checks++; if (!ok || res !== 32'h80000000) begin failures++; $display("FAIL div_overflow got=%h ok=%0d exp=80000000", res, ok); end
    checks++; if (s !== 1) begin failures++; $display("FAIL ovf_stalls got=%0d exp=1", s); end
  endtask
  task automatic test_flush();
    int s; logic [31:0] res; bit ok; bit seen;
    @(negedge clk);
    op = 3'd4; srca = 32'd1000; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    checks++; if (result !== 32'h80000000) begin failures++; $display("FAIL flush_result_hold got=%h exp=80000000", result); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL flush_no_done got=1 exp=0"); end
    run_op(3'd0, 32'd3, 32'd4, s, res, ok);
    checks++; if (!ok || res !== 32'd12) begin failures++; $display("FAIL mul_after_flush got=%h ok=%0d exp=0000000c", res, ok); end
  endtask
  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    op = 3'd0; srca = 32'd9; srcb = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", stall); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=0", result); end
    @(negedge clk); reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || stall) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midreset_no_activity got=1 exp=0"); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
